// File: rtl/divide_sequencer_pkg.sv
// Shared constants for the LEGv8 multi-cycle divider: datapath width, iteration count, FSM states.
package divide_sequencer_pkg;

  localparam int DATA_W   = 64;
  localparam int DS_ITERS = 64;

  typedef enum logic [2:0] {
    DS_IDLE = 3'd0,
    DS_PREP = 3'd1,
    DS_ITER = 3'd2,
    DS_FIX  = 3'd3,
    DS_DONE = 3'd4
  } ds_state_t;

endpackage

// File: rtl/divide_sequencer_sub.sv
// 64-bit subtractor a - b as a + ~b + carry_in; carry_out=1 means no borrow.
module divide_sequencer_sub
  import divide_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carry_in,
  output logic [DATA_W-1:0] diff,
  output logic              carry_out
);

  assign {carry_out, diff} = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, carry_in};

endmodule

// File: rtl/divide_sequencer.sv
// Restoring divider controller, one quotient bit per cycle on a shared subtractor (67-cycle latency, 2 on divide-by-zero).
// Define DIV_SIGNED_EN to build SDIV support (operand magnitude in PREP, sign fix in FIX).
module divide_sequencer
  import divide_sequencer_pkg::*;
#(
  parameter int ITERS = DS_ITERS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int            CW   = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  ds_state_t         state;
  logic [DATA_W-1:0] dvd_r, dvs_r, dvs_mag, q_sh, r_part;
  logic [CW-1:0]     cnt;

  logic [DATA_W:0]   s_val;
  logic [DATA_W-1:0] trial_diff;
  logic              trial_cout, success;

  logic [DATA_W-1:0] dvd_mag_c, dvs_mag_c, q_fix_c, r_fix_c;

  assign s_val = {r_part, q_sh[DATA_W-1]};

  divide_sequencer_sub u_trial (
    .a         (s_val[DATA_W-1:0]),
    .b         (dvs_mag),
    .carry_in  (1'b1),
    .diff      (trial_diff),
    .carry_out (trial_cout)
  );

  assign success = s_val[DATA_W] | trial_cout;

`ifdef DIV_SIGNED_EN
  logic              sgn_r, neg_q, neg_r;
  logic [DATA_W-1:0] neg_x_in, neg_y_in, neg_x, neg_y;
  logic              unused_cout_x, unused_cout_y;

  // PREP and FIX never overlap, so one negator pair serves both.
  assign neg_x_in = (state == DS_PREP) ? dvd_r : q_sh;
  assign neg_y_in = (state == DS_PREP) ? dvs_r : r_part;

  divide_sequencer_sub u_neg_x (
    .a         ({DATA_W{1'b0}}),
    .b         (neg_x_in),
    .carry_in  (1'b1),
    .diff      (neg_x),
    .carry_out (unused_cout_x)
  );

  divide_sequencer_sub u_neg_y (
    .a         ({DATA_W{1'b0}}),
    .b         (neg_y_in),
    .carry_in  (1'b1),
    .diff      (neg_y),
    .carry_out (unused_cout_y)
  );

  assign dvd_mag_c = (sgn_r & dvd_r[DATA_W-1]) ? neg_x : dvd_r;
  assign dvs_mag_c = (sgn_r & dvs_r[DATA_W-1]) ? neg_y : dvs_r;
  assign q_fix_c   = neg_q ? neg_x : q_sh;
  assign r_fix_c   = neg_r ? neg_y : r_part;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sgn_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == DS_IDLE && start) begin
      sgn_r <= div_signed;
    end else if (state == DS_PREP) begin
      neg_q <= sgn_r & (dvd_r[DATA_W-1] ^ dvs_r[DATA_W-1]);
      neg_r <= sgn_r & dvd_r[DATA_W-1];
    end
  end
`else
  logic unused_div_signed;

  assign unused_div_signed = div_signed;
  assign dvd_mag_c         = dvd_r;
  assign dvs_mag_c         = dvs_r;
  assign q_fix_c           = q_sh;
  assign r_fix_c           = r_part;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= DS_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      dvs_mag     <= '0;
      q_sh        <= '0;
      r_part      <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        DS_IDLE: begin
          if (start) begin
            dvd_r       <= dividend;
            dvs_r       <= divisor;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= DS_PREP;
          end
        end
        DS_PREP: begin
          r_part  <= '0;
          cnt     <= '0;
          q_sh    <= dvd_mag_c;
          dvs_mag <= dvs_mag_c;
          if (dvs_r == '0) begin
            div_by_zero <= 1'b1;
            quotient    <= '0;
            remainder   <= dvd_r;
            done        <= 1'b1;
            state       <= DS_DONE;
          end else begin
            state <= DS_ITER;
          end
        end
        DS_ITER: begin
          // R stays below the divisor, so a failed trial always has S[64]=0 and 64 bits hold R.
          r_part <= success ? trial_diff : s_val[DATA_W-1:0];
          q_sh   <= {q_sh[DATA_W-2:0], success};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) state <= DS_FIX;
        end
        DS_FIX: begin
          quotient  <= q_fix_c;
          remainder <= r_fix_c;
          done      <= 1'b1;
          state     <= DS_DONE;
        end
        DS_DONE: begin
          busy  <= 1'b0;
          state <= DS_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= DS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide_sequencer.sv
// Bench for divide_sequencer: per-cycle comparison against an arithmetic reference model plus directed literal cases.
module tb_divide_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, div_signed;
  logic [63:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [63:0] quotient, remainder;

  int n_chk  = 0;
  int n_fail = 0;

  divide_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .div_signed  (div_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division semantics.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input logic sg,
                                  output logic [63:0] q, output logic [63:0] r, output logic dz);
    longint sa, sb;
    sa = a;
    sb = b;
    dz = (b == 64'd0);
    q  = a / b;
    r  = a % b;
    if (dz) begin
      q = 64'd0;
      r = a;
    end
`ifdef DIV_SIGNED_EN
    else if (sg) begin
      if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a;
        r = 64'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end
`else
    if (sg && sa == sb) q = q;
`endif
  endfunction

  // Cycle-level model: latency is 67 cycles, or 2 on a zero divisor.
  bit          m_active = 1'b0;
  int          m_cyc = 0, m_lat = 0;
  logic [63:0] p_q, p_r, o_q = '0, o_r = '0;
  logic        p_dz, o_dz = 1'b0;
  logic        s_rst, s_start, s_sg;
  logic [63:0] s_a, s_b;

  always @(posedge clk) begin
    s_rst   = reset;
    s_start = start;
    s_sg    = div_signed;
    s_a     = dividend;
    s_b     = divisor;
    #1;
    if (s_rst) begin
      m_active = 1'b0;
      o_q = '0; o_r = '0; o_dz = 1'b0;
    end else if (m_active) begin
      m_cyc++;
      if (m_cyc == m_lat) begin
        o_q = p_q; o_r = p_r; o_dz = p_dz;
      end else if (m_cyc > m_lat) begin
        m_active = 1'b0;
      end
    end else if (s_start) begin
      ref_div(s_a, s_b, s_sg, p_q, p_r, p_dz);
      m_lat    = p_dz ? 2 : 67;
      m_cyc    = 1;
      m_active = 1'b1;
      o_dz     = 1'b0;
    end
    chk("mon_busy", 64'(busy), 64'(m_active));
    chk("mon_done", 64'(done), 64'(m_active && m_cyc == m_lat));
    chk("mon_quotient", quotient, o_q);
    chk("mon_remainder", remainder, o_r);
    chk("mon_div_by_zero", 64'(div_by_zero), 64'(o_dz));
  end

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sg, input bit early,
                        input int restart_at, input int reset_at, output int lat,
                        output logic [63:0] q, output logic [63:0] r, output logic dz);
    if (!early) begin
      @(posedge clk); #1;
    end
    dividend = a; divisor = b; div_signed = sg; start = 1'b1;
    if (early) begin
      @(posedge clk); #1;
      chk("start_at_done_ignored", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      start = (restart_at != 0 && lat == restart_at);
      if (reset_at != 0 && lat == reset_at) begin
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_quotient", quotient, 64'd0);
        chk("rst_mid_remainder", remainder, 64'd0);
        chk("rst_mid_dbz", 64'(div_by_zero), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        lat = 0; q = '0; r = '0; dz = 1'b0;
        return;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("done_within_budget", 64'(done), 64'd1);
    q = quotient; r = remainder; dz = div_by_zero;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [63:0] q, r, mq, mr, a, b;
    logic        dz, md, sg;

    reset = 1'b1; start = 1'b0; div_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_quotient", quotient, 64'd0);
    chk("reset_remainder", remainder, 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);

    ref_div(64'd100, 64'd7, 1'b0, mq, mr, md);
    chk("model_100_7_q", mq, 64'd14);
    chk("model_100_7_r", mr, 64'd2);
    ref_div(64'h1234, 64'd0, 1'b0, mq, mr, md);
    chk("model_dbz_r", mr, 64'h1234);
    chk("model_dbz_flag", 64'(md), 64'd1);

    reset = 1'b0;

    run_op(64'd100, 64'd7, 1'b0, 1'b0, 0, 0, lat, q, r, dz);
    chk("u100_7_latency", 64'(lat), 64'd67);
    chk("u100_7_q", q, 64'd14);
    chk("u100_7_r", r, 64'd2);
    chk("u100_7_dbz", 64'(dz), 64'd0);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0, 0, lat, q, r, dz);
    chk("s64_path_q", q, 64'd1);
    chk("s64_path_r", r, 64'h7FFF_FFFF_FFFF_FFFF);

    run_op(64'h1234, 64'd0, 1'b0, 1'b0, 0, 0, lat, q, r, dz);
    chk("dbz_latency", 64'(lat), 64'd2);
    chk("dbz_flag", 64'(dz), 64'd1);
    chk("dbz_q", q, 64'd0);
    chk("dbz_r", r, 64'h1234);

`ifdef DIV_SIGNED_EN
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 0, 0, lat, q, r, dz);
    chk("sneg7_2_q", q, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("sneg7_2_r", r, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0, 0, lat, q, r, dz);
    chk("smin_neg1_q", q, 64'h8000_0000_0000_0000);
    chk("smin_neg1_r", r, 64'd0);
    chk("smin_neg1_dbz", 64'(dz), 64'd0);
`endif

    run_op(64'd1000, 64'd10, 1'b0, 1'b0, 30, 0, lat, q, r, dz);
    chk("restart_ignored_latency", 64'(lat), 64'd67);
    chk("restart_ignored_q", q, 64'd100);
    chk("restart_ignored_r", r, 64'd0);

    run_op(64'd55, 64'd5, 1'b0, 1'b1, 0, 0, lat, q, r, dz);
    chk("b2b_latency", 64'(lat), 64'd67);
    chk("b2b_q", q, 64'd11);

    run_op(64'd12345, 64'd17, 1'b0, 1'b0, 0, 40, lat, q, r, dz);
    run_op(64'd9, 64'd3, 1'b0, 1'b0, 0, 0, lat, q, r, dz);
    chk("post_reset_q", q, 64'd3);
    chk("post_reset_r", r, 64'd0);

    for (int i = 0; i < 40; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 15));
        2: a = 64'($urandom_range(0, 1000));
        3: begin a = 64'h8000_0000_0000_0000; b = 64'hFFFF_FFFF_FFFF_FFFF; end
        4: b = {32'd0, $urandom};
        default: ;
      endcase
      run_op(a, b, sg, bit'($urandom_range(0, 1)), 0, 0, lat, q, r, dz);
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/divide_sequencer.md
# divide_sequencer

Multi-cycle 64-bit integer divider controller for the LEGv8 execute stage. It implements restoring division, one quotient bit per cycle, by sequencing a single shared 64-bit subtractor instance. It serves UDIV and, when configured, SDIV. The ALU control issues a start pulse and stalls the pipeline while busy is high.

## Interface
Parameters:
- ITERS, 64: number of quotient bits. Equals operand width and is not intended to change.

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- div_signed  input  1  1 = SDIV semantics; ignored unless DIV_SIGNED_EN is defined
- dividend  input  64  numerator; sampled with start
- divisor  input  64  denominator; sampled with start
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted, inclusive
- done  output  1  single-cycle pulse; results are valid from this cycle on
- quotient  output  64  result quotient
- remainder  output  64  result remainder
- div_by_zero  output  1  sticky flag for the last operation; cleared on the next accepted start

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: if start=1, latch the operands and div_signed, clear div_by_zero, then go to PREP. A start in any other state is ignored.
- PREP:
  - Signed mode: convert both operands to magnitude and record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Clear the 65-bit partial remainder R and the iteration counter.
  - Load the quotient shift register Q with the dividend magnitude.
  - If the divisor is 0: set div_by_zero, quotient=0, remainder=raw dividend, and go to DONE, skipping ITER and FIX.
  - Otherwise go to ITER.
- ITER, one iteration per cycle:
  - Compute S = {R[63:0], Q[63]}.
  - Trial-subtract S[63:0] − divisor magnitude using the subtractor (carry_in=1).
  - The trial succeeds when S[64]=1 or carry_out=1. On success R ← difference; otherwise R ← S.
  - Q ← {Q[62:0], success}.
  - After the 64th iteration (counter = ITERS−1), go to FIX.
- FIX: quotient ← neg_q ? −Q : Q; remainder ← neg_r ? −R[63:0] : R[63:0], using two's-complement 64-bit wrap. Go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- quotient, remainder and div_by_zero hold their values until the next operation overwrites them.
- Arithmetic rules:
  - The remainder always satisfies dividend = quotient·divisor + remainder modulo 2^64.
  - The remainder's sign follows the dividend.
  - Signed −2^63 / −1 yields quotient 0x8000_0000_0000_0000 and remainder 0, with no flag.

## Timing
- Reset, asynchronous: state=IDLE; busy, done, div_by_zero, quotient and remainder all 0; internal registers 0.
- Reset asserted mid-operation aborts the operation with no done pulse.
- Normal latency: start sampled at edge 0; PREP at cycle 1, ITER at cycles 2–65, FIX at cycle 66, done=1 at cycle 67. busy is high for cycles 1–67.
- Divide by zero: done=1 at cycle 2; busy is high for cycles 1–2.
- Back-to-back: a start presented in the same cycle as done is ignored. The earliest next start is the cycle after done, when the block is back in IDLE.
- Inputs are not required to be held after the accepting edge.

## Configuration
- DIV_SIGNED_EN
  - Defined: div_signed selects SDIV handling (magnitude conversion in PREP, sign fix in FIX).
  - Undefined: div_signed is ignored, neg_q and neg_r are tied to 0, and the negation logic is not built. Latency is unchanged, and FIX remains a one-cycle pass-through.

## Structure
- Shared package, or header for plain Verilog:
  - state encoding constants (DS_IDLE, DS_PREP, DS_ITER, DS_FIX, DS_DONE);
  - ITERS default;
  - the 64-bit data width constant shared with the ALU.
- One sub-module: the existing 64-bit subtractor, instantiated once for the trial subtract. The FSM, counter and shift registers stay in this module.
- The PREP and FIX negations use the same subtractor form with operand 0. A second instance is acceptable, or they can be muxed onto the single instance because those states never overlap with ITER.

## Test plan
- Unsigned 100 / 7 → quotient 14, remainder 2, done at cycle 67, busy high for 67 cycles.
- Unsigned 0xFFFF_FFFF_FFFF_FFFF / 0x8000_0000_0000_0000 → quotient 1, remainder 0x7FFF_FFFF_FFFF_FFFF. Exercises the S[64] success path.
- Divisor 0, dividend 0x1234 → div_by_zero=1, quotient 0, remainder 0x1234, done at cycle 2.
- With DIV_SIGNED_EN: −7 / 2 → quotient −3, remainder −1. Also −2^63 / −1 → quotient 0x8000_0000_0000_0000, remainder 0.
- Start re-asserted at cycle 30 of a running operation is ignored and the results match the first operation. Start on the cycle after done is accepted.
- Reset asserted at cycle 40 → all outputs 0 immediately, no done pulse, and a subsequent 9 / 3 returns quotient 3, remainder 0.
